// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone register-file slave.
// Holds the bus FSM state encoding and the lane-select to bit-mask expansion.
package wb_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_RESP,
        STATE_WAIT_END
    } state_t;

    localparam int unsigned MAX_WIDTH = 64;

    // Bit i of the result copies the select bit of the granule that contains bit i.
    function automatic logic [MAX_WIDTH-1:0] sel_to_mask(input logic [MAX_WIDTH-1:0] sel,
                                                         input int unsigned granule);
        logic [MAX_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            mask[6'(i)] = sel[6'(i / int'(granule))];
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_lane_merge.sv
// Lane-wise merge: selected granules come from new_i, the rest from old_i.
// Serves both the bus write path and the read-data lane masking.
module wb_lane_merge
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GRANULE    = 8,
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE
) (
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] new_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    logic [MAX_WIDTH-1:0]  mask_wide;
    logic [DATA_WIDTH-1:0] mask;
    logic                  unused_mask;

    always_comb begin
        mask_wide = sel_to_mask({{(MAX_WIDTH - SEL_WIDTH){1'b0}}, sel_i}, GRANULE);
        mask      = mask_wide[DATA_WIDTH-1:0];
        merged_o  = (old_i & ~mask) | (new_i & mask);
    end

    assign unused_mask = ^mask_wide;

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic slave register file with byte-lane writes, read-only mask,
// hardware update port, per-register write strobes and error on out-of-range index.
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GRANULE    = 8,
    parameter int unsigned NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE,
    localparam int unsigned ADDR_LSB  = $clog2(DATA_WIDTH / 8)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          adr_i,
    input  logic [DATA_WIDTH-1:0]          dat_i,
    output logic [DATA_WIDTH-1:0]          dat_o,
    input  logic [SEL_WIDTH-1:0]           sel_i,
    input  logic                           we_i,
    input  logic                           stb_i,
    input  logic                           cyc_i,
    output logic                           ack_o,
    output logic                           err_o,
    input  logic [NUM_REGS-1:0]            hw_we_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_dat_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            wr_stb_o
);

    localparam int unsigned IDX_W = ADDR_WIDTH - ADDR_LSB;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] dat_q;
    logic [NUM_REGS-1:0]   wr_stb_q;

    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  access;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_masked;

    always_comb begin
        idx      = adr_i[ADDR_WIDTH-1:ADDR_LSB];
        in_range = (32'(idx) < 32'(NUM_REGS));
        rd_word  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == IDX_W'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    generate
        if (ADDR_LSB > 0) begin : g_addr_lsb
            logic unused_adr;
            assign unused_adr = ^adr_i[ADDR_LSB-1:0];
        end
    endgenerate

    wb_lane_merge #(
        .DATA_WIDTH(DATA_WIDTH),
        .GRANULE   (GRANULE)
    ) u_wr_merge (
        .old_i   (rd_word),
        .new_i   (dat_i),
        .sel_i   (sel_i),
        .merged_o(wr_word)
    );

    wb_lane_merge #(
        .DATA_WIDTH(DATA_WIDTH),
        .GRANULE   (GRANULE)
    ) u_rd_merge (
        .old_i   ({DATA_WIDTH{1'b0}}),
        .new_i   (rd_word),
        .sel_i   (sel_i),
        .merged_o(rd_masked)
    );

    // The access happens on the RESP edge unless the master has abandoned the cycle.
    assign access = (state_q == STATE_RESP) && cyc_i;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        unique case (state_q)
            STATE_IDLE: begin
                if (cyc_i && stb_i) begin
                    ack_d   = in_range;
                    err_d   = !in_range;
                    state_d = STATE_RESP;
                end
            end
            STATE_RESP: begin
                if (!cyc_i) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = STATE_IDLE;
                end else begin
                    state_d = STATE_WAIT_END;
                end
            end
            STATE_WAIT_END: begin
                if (!cyc_i || !stb_i) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = STATE_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= STATE_IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            wr_stb_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            wr_stb_q <= '0;
            if (access && err_q) begin
                dat_q <= '0;
            end else if (access && !we_i) begin
                dat_q <= rd_masked;
            end
            for (int k = 0; k < NUM_REGS; k++) begin
                // Hardware update takes priority; the strobe still reports the bus write.
                if (hw_we_i[k]) begin
                    regs_q[k] <= hw_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                end else if (access && ack_q && we_i && !RO_MASK[k] && idx == IDX_W'(k)) begin
                    regs_q[k] <= wr_word;
                end
                if (access && ack_q && we_i && !RO_MASK[k] && idx == IDX_W'(k) && |sel_i) begin
                    wr_stb_q[k] <= 1'b1;
                end
            end
        end
    end

    // Response is only exposed once the access edge has passed.
    always_comb begin
        ack_o    = ack_q && (state_q == STATE_WAIT_END) && stb_i && cyc_i;
        err_o    = err_q && (state_q == STATE_WAIT_END) && stb_i && cyc_i;
        dat_o    = dat_q;
        wr_stb_o = wr_stb_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench for wb_slave_regfile: a table of single bus transactions
// plus hand-written sequences for hw collision, reset and abort corners.
module tb_wb_slave_regfile;

    localparam int unsigned NR = 6;
    localparam logic [191:0] RST_VAL = {32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_0001, 32'h0};

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [15:0]   adr_i;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic [3:0]    sel_i;
    logic          we_i, stb_i, cyc_i, ack_o, err_o;
    logic [NR-1:0] hw_we_i;
    logic [191:0]  hw_dat_i;
    logic [191:0]  reg_o;
    logic [NR-1:0] wr_stb_o;

    always #5 clk_i = ~clk_i;

    wb_slave_regfile #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .GRANULE   (8),
        .NUM_REGS  (NR),
        .RO_MASK   (6'b100000),
        .RESET_VAL (RST_VAL)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .sel_i   (sel_i),
        .we_i    (we_i),
        .stb_i   (stb_i),
        .cyc_i   (cyc_i),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .hw_we_i (hw_we_i),
        .hw_dat_i(hw_dat_i),
        .reg_o   (reg_o),
        .wr_stb_o(wr_stb_o)
    );

    typedef struct {
        logic [15:0]   adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          we;
        logic          ack;
        logic          err;
        logic [31:0]   rdat;
        logic [NR-1:0] wstb;
    } vec_t;

    vec_t vecs[13];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, output logic [31:0] rd, output logic ak,
                       output logic er, output int lat, output logic [NR-1:0] ws,
                       output logic [NR-1:0] ws_after);
        @(posedge clk_i); #1;
        adr_i = a; dat_i = d; sel_i = s; we_i = w; cyc_i = 1'b1; stb_i = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            lat++;
            if (ack_o || err_o) break;
        end
        ak = ack_o; er = err_o; rd = dat_o; ws = wr_stb_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        ws_after = wr_stb_o;
    endtask

    initial begin
        logic [31:0]   rd;
        logic          ak, er;
        int            lat;
        logic [NR-1:0] ws, wsa;

        //            adr       dat            sel    we    ack   err   rdat           wstb
        vecs[0]  = '{16'h0004, 32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 6'b0};
        vecs[1]  = '{16'h0008, 32'h1122_3344, 4'h5, 1'b1, 1'b1, 1'b0, 32'h0,         6'b000100};
        vecs[2]  = '{16'h0008, 32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 32'h0022_0044, 6'b0};
        vecs[3]  = '{16'h0008, 32'h0,         4'h3, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 6'b0};
        vecs[4]  = '{16'h0014, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0,         6'b0};
        vecs[5]  = '{16'h0014, 32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 32'h0,         6'b0};
        vecs[6]  = '{16'h0018, 32'h0,         4'hF, 1'b0, 1'b0, 1'b1, 32'h0,         6'b0};
        vecs[7]  = '{16'h0018, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b1, 32'h0,         6'b0};
        vecs[8]  = '{16'h0010, 32'h0000_00FF, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0,         6'b0};
        vecs[9]  = '{16'h0010, 32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 32'h0,         6'b0};
        vecs[10] = '{16'h0000, 32'hA5A5_5A5A, 4'hC, 1'b1, 1'b1, 1'b0, 32'h0,         6'b000001};
        vecs[11] = '{16'h0000, 32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 32'hA5A5_0000, 6'b0};
        vecs[12] = '{16'h0004, 32'h0,         4'h8, 1'b0, 1'b1, 1'b0, 32'hCA00_0000, 6'b0};

        rst_i = 1'b1; adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0;
        stb_i = 1'b0; cyc_i = 1'b0; hw_we_i = '0; hw_dat_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("reset reg_o", reg_o, RST_VAL);
        chk("reset dat_o", dat_o, 32'h0);
        chk("reset ack/err", {ack_o, err_o}, 2'b00);
        chk("reset wr_stb", wr_stb_o, 6'b0);

        for (int v = 0; v < 13; v++) begin
            bus(vecs[v].adr, vecs[v].dat, vecs[v].sel, vecs[v].we, rd, ak, er, lat, ws, wsa);
            chk($sformatf("v%0d ack", v), ak, vecs[v].ack);
            chk($sformatf("v%0d err", v), er, vecs[v].err);
            chk($sformatf("v%0d latency", v), lat, 2);
            chk($sformatf("v%0d wr_stb", v), ws, vecs[v].wstb);
            chk($sformatf("v%0d wr_stb after", v), wsa, 6'b0);
            if (!vecs[v].we) chk($sformatf("v%0d dat_o", v), rd, vecs[v].rdat);
        end
        chk("reg5 ro kept", reg_o[191:160], 32'h0);
        chk("reg2 lanes", reg_o[95:64], 32'h0022_0044);

        // Hardware write collides with a bus write to reg3: hardware wins.
        @(posedge clk_i); #1;
        adr_i = 16'h000C; dat_i = 32'h0; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk_i); #1;
        hw_we_i = 6'b001000; hw_dat_i = '0; hw_dat_i[127:96] = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        hw_we_i = '0;
        chk("hw collide ack", ack_o, 1'b1);
        chk("hw collide wr_stb", wr_stb_o, 6'b001000);
        chk("hw collide reg3", reg_o[127:96], 32'hDEAD_BEEF);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("hw collide reg3 held", reg_o[127:96], 32'hDEAD_BEEF);

        // Read at the same edge as a hardware update returns the old value.
        adr_i = 16'h000C; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk_i); #1;
        hw_we_i = 6'b001000; hw_dat_i[127:96] = 32'h1234_5678;
        @(posedge clk_i); #1;
        hw_we_i = '0;
        chk("hw read old", dat_o, 32'hDEAD_BEEF);
        chk("hw read reg3 new", reg_o[127:96], 32'h1234_5678);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk_i); #1;

        // cyc_i dropped during RESP: write abandoned.
        adr_i = 16'h0010; dat_i = 32'h0000_0077; sel_i = 4'hF; we_i = 1'b1;
        cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("abort reg4", reg_o[159:128], 32'h0);
        chk("abort wr_stb", wr_stb_o, 6'b0);
        bus(16'h0004, 32'h0, 4'hF, 1'b0, rd, ak, er, lat, ws, wsa);
        chk("after abort latency", lat, 2);
        chk("after abort dat_o", rd, 32'hCAFE_0001);

        // Reset during RESP of a write to reg0.
        @(posedge clk_i); #1;
        adr_i = 16'h0000; dat_i = 32'h1234_5678; sel_i = 4'hF; we_i = 1'b1;
        cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("rst mid ack", {ack_o, err_o}, 2'b00);
        chk("rst mid reg_o", reg_o, RST_VAL);
        chk("rst mid wr_stb", wr_stb_o, 6'b0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst mid idle", {ack_o, err_o}, 2'b00);
        bus(16'h0008, 32'h0, 4'hF, 1'b0, rd, ak, er, lat, ws, wsa);
        chk("after rst latency", lat, 2);
        chk("after rst reg2", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
